// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU control decode with RV32M latency sequencing,
// valid/ready back-pressure and pipeline flush.
module alu_ctrl_stage #(
  parameter int CTRL_W  = 5,
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op5,
  input  logic              out_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [1:0]        DataType,
  output logic              MemSigned,
  output logic              illegal,
  output logic              m_busy,
  output logic              mdu_start,
  output logic              mdu_kill
);
  localparam int CW = $clog2(DIV_LAT) + 1;
  localparam logic [CW-1:0] MUL_L = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_LAT - 1);
  localparam logic [6:0] F7_Z = 7'b0000000;
  localparam logic [6:0] F7_S = 7'b0100000;
  localparam logic [6:0] F7_M = 7'b0000001;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [1:0]        dt_q, dt_d;
  logic              ms_q, ms_d;
  logic              ill_q, ill_d;
  logic              start_q, start_d;
  logic              kill_q, kill_d;

  logic [4:0]    code;
  logic [1:0]    dt;
  logic          ms, ill, is_m, acc;
  logic [CW-1:0] lat;

  always_comb begin
    code = 5'd0;
    dt   = 2'b00;
    ms   = 1'b0;
    ill  = 1'b0;
    is_m = 1'b0;
    if (ALUOp == 2'b00) begin
      dt  = funct3[1:0] == 2'b00 ? 2'b01 : funct3[1:0] == 2'b01 ? 2'b10 : 2'b00;
      ms  = ~funct3[2];
      ill = &funct3[1:0];
    end else if (ALUOp == 2'b01) begin
      code = funct3[2:1] == 2'b00 ? 5'd1 : funct3[2:1] == 2'b10 ? 5'd5 : 5'd10;
      ill  = funct3[2:1] == 2'b01;
    end else if (ALUOp == 2'b10) begin
      is_m = EN_M && op5 && funct7 == F7_M;
      ill  = op5 && !(funct7 == F7_Z || funct7 == F7_S || (EN_M && funct7 == F7_M));
      case (funct3)
        3'b000:  code = (op5 && funct7 == F7_S) ? 5'd1 : 5'd0;
        3'b001:  code = 5'd4;
        3'b010:  code = 5'd5;
        3'b011:  code = 5'd10;
        3'b100:  code = 5'd9;
        3'b101:  code = funct7[5] ? 5'd7 : 5'd6;
        3'b110:  code = 5'd3;
        default: code = 5'd2;
      endcase
      if (is_m) code = {2'b10, funct3};
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      code = 5'd0;
      dt   = 2'b00;
      ms   = 1'b0;
    end
  end

  assign lat      = funct3[2] ? DIV_L : MUL_L;
  assign m_busy   = state_q == BUSY;
  assign in_ready = !m_busy && (!ov_q || out_ready);
  // Flush drops the same-cycle input, so it gates the accept itself.
  assign acc      = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ctrl_q  <= '0;
      dt_q    <= 2'b00;
      ms_q    <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      ctrl_q  <= ctrl_d;
      dt_q    <= dt_d;
      ms_q    <= ms_d;
      ill_q   <= ill_d;
      start_q <= start_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      if (cnt_q == '0) state_d = IDLE;
      else cnt_d = cnt_q - 1'b1;
    end else if (acc && is_m) begin
      state_d = BUSY;
      cnt_d   = lat;
    end
  end

  always_comb begin
    ov_d    = flush ? 1'b0 : acc ? !is_m : (m_busy && cnt_q == '0) ? 1'b1 : out_ready ? 1'b0 : ov_q;
    ctrl_d  = acc ? CTRL_W'(code) : ctrl_q;
    dt_d    = acc ? dt : dt_q;
    ms_d    = acc ? ms : ms_q;
    ill_d   = acc ? ill : ill_q;
    start_d = acc && is_m;
    kill_d  = flush && m_busy;
  end

  assign out_valid  = ov_q;
  assign ALUControl = ctrl_q;
  assign DataType   = dt_q;
  assign MemSigned  = ms_q;
  assign illegal    = ill_q;
  assign mdu_start  = start_q;
  assign mdu_kill   = kill_q;
endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, parametrised ALU control stage for the pipelined RV32I/M core, sitting between the main decoder and the execute stage. It decodes `ALUOp`, `funct3` and `funct7` into a full ALU control code, memory data type and signedness. It sequences multi-cycle RV32M operations with a latency counter and applies valid/ready back-pressure upstream. It also supports pipeline flush.

## Interface
- `CTRL_W`, 5: ALU control width; must be at least 5.
- `EN_M`, 1: 1 decodes RV32M; 0 flags M encodings as illegal.
- `MUL_LAT`, 2: cycles from accept to result for MUL/MULH/MULHSU/MULHU; must be at least 1.
- `DIV_LAT`, 32: cycles from accept to result for DIV/DIVU/REM/REMU; must be at least 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept (combinational).
- `ALUOp`  in  2  00 load/store, 01 branch, 10 R/I arithmetic, 11 reserved.
- `funct3`  in  3  instruction funct3.
- `funct7`  in  7  instruction funct7.
- `op5`  in  1  opcode bit 5: 1 R-type, 0 I-type.
- `out_ready`  in  1  execute stage can take the result.
- `flush`  in  1  synchronous pipeline flush.
- `out_valid`  out  1  registered outputs are valid.
- `ALUControl`  out  CTRL_W  registered ALU code.
- `DataType`  out  2  registered: 00 word, 01 byte, 10 half, 11 unused.
- `MemSigned`  out  1  registered: equals ~funct3[2] for loads.
- `illegal`  out  1  registered: encoding not decodable.
- `m_busy`  out  1  M operation in progress.
- `mdu_start`  out  1  one-cycle pulse to the MDU.
- `mdu_kill`  out  1  one-cycle pulse that aborts the MDU.

## Operation
- Accept: `in_valid && in_ready`.
  - `in_ready = !m_busy && (!out_valid || out_ready)`.
- ALUOp 00: code 0 (add).
  - `DataType`: funct3[1:0] 00→01, 01→10, 10→00, 11→illegal.
  - `MemSigned` = ~funct3[2].
- ALUOp 01 (branch):
  - funct3 000/001 → 1 (sub).
  - funct3 100/101 → 5 (slt).
  - funct3 110/111 → 10 (sltu).
  - funct3 010/011 → illegal.
- ALUOp 10, base codes:
  - add 0, sub 1, and 2, or 3, sll 4, slt 5, srl 6, sra 7, xor 9, sltu 10.
  - SUB only when op5=1 and funct7=0100000. ADDI is always add.
  - funct3 101: funct7[5]=1 → sra, else srl, for both R- and I-type.
  - R-type with funct7 not in {0000000, 0100000, 0000001} → illegal.
- M op: `EN_M`=1, ALUOp=10, op5=1, funct7=0000001.
  - Code = 16 + funct3.
  - Latency: `MUL_LAT` if funct3[2]=0, else `DIV_LAT`.
- ALUOp 11, or any illegal case: code 0, `illegal`=1, `DataType` 00, `MemSigned` 0.
- State machine:
  - IDLE → (accept M op) BUSY, counter loaded with LAT−1.
  - BUSY → counter decrements each cycle. At 0, transitions to IDLE with `out_valid`=1.
  - Non-M accept stays in IDLE and loads the output register.
- Output register holds while `out_valid && !out_ready`.
- `out_valid` clears on `out_ready` unless a new accept occurs in the same cycle.
- Flush (highest priority):
  - Next edge: `out_valid`=0 and state IDLE.
  - Same-cycle input is dropped.
  - If in BUSY, `mdu_kill`=1 for one cycle.
  - Decoded fields keep their values.

## Timing
- Reset values of all registered outputs: `out_valid` 0, `ALUControl` 0, `DataType` 00, `MemSigned` 0, `illegal` 0, `m_busy` 0, `mdu_start` 0, `mdu_kill` 0. State IDLE, counter 0, so `in_ready`=1.
- Reset asserted mid-BUSY aborts immediately, with no `mdu_kill`.
- Non-M op: accepted at edge T, output valid after T. Throughput 1 per cycle when `out_ready`=1.
- M op accepted at edge T:
  - `m_busy` and `mdu_start` rise after T; `mdu_start` falls after T+1.
  - `ALUControl` is valid from T.
  - `out_valid` rises and `m_busy` falls after T+LAT.
  - With LAT=1: `m_busy` lasts one cycle, and `out_valid` rises after T+1.
- Counter width is $clog2(DIV_LAT)+1. No wrap-around; it decrements only in BUSY.
- Flush and the counter reaching 0 in the same cycle: flush wins; `out_valid` stays 0 and `mdu_kill` fires.

## Test plan
- Reset with `rst_n`=0 asynchronously mid-cycle → all outputs 0 immediately, `in_ready`=1.
- Back-to-back R-type SUB (funct7=0x20, funct3=0, op5=1), SRA (funct7=0x20, funct3=5), SLTU, with `out_ready`=1 → codes 1, 7, 10 on three consecutive cycles. ADDI with funct7 bits=0x20 → 0.
- Loads with funct3 = 000, 001, 010, 100, 101, 011 → `DataType`/`MemSigned`/`illegal` = 01/1/0, 10/1/0, 00/1/0, 01/0/0, 10/0/0, and `illegal`=1.
- DIV (funct7=1, funct3=4) with `DIV_LAT`=32 → code 20, `mdu_start` single pulse, `in_ready`=0 for 32 cycles, `out_valid` after 32 edges. Repeat with `EN_M`=0 → `illegal`=1, no busy.
- Flush at cycle 10 of a DIV → `mdu_kill` one pulse, `out_valid` never rises, `in_ready`=1 the next cycle.
- `out_ready`=0 for 5 cycles after an XOR → `ALUControl`=9 held stable, `in_ready`=0, and the next instruction is accepted on the release cycle.
